// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared state enum, idle pin levels and default sizes for 74HC165 chain readers.
package shift_reg_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_e;
  localparam logic PL_IDLE = 1'b1;
  localparam logic CP_IDLE = 1'b0;
  localparam logic CE_IDLE = 1'b1;
  localparam int WIDTH_DEF = 8;
  localparam int CLK_DIV_DEF = 4;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for asynchronous board inputs.
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both flops
//   d_i  - asynchronous input
//   q_o  - synchronised output, two clk cycles behind d_i
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/shift_reg_rd.sv
// shift_reg_rd: reader for a 74HC165 parallel-in/serial-out chain, MSB-first.
//   clk/rst        - common clock, asynchronous active-high reset
//   rd_en          - read request, accepted only in IDLE
//   rd_busy        - high from LOAD through DONE
//   rd_vld/rd_data - one-cycle strobe with the captured word (bit WIDTH-1 shifted first)
//   o_PL/o_CP/o_CE - chain parallel-load (low), serial clock, clock-enable (low)
//   i_Q7           - serial data from the chain, asynchronous to clk
module shift_reg_rd
  import shift_reg_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  output logic             rd_busy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_data,
  output logic             o_PL,
  output logic             o_CP,
  output logic             o_CE,
  input  logic             i_Q7
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic q7_s;
  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic div_end;
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (i_Q7),
    .q_o (q7_s)
  );
  assign div_end = (div_q == DW'(CLK_DIV - 1));
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE:     state_d = rd_en ? LOAD : IDLE;
      LOAD:     if (div_end) begin
                  state_d = SHIFT_LO;
                  bit_d   = BW'(WIDTH - 1);
                end
      SHIFT_LO: if (div_end) begin
                  sh_d    = {sh_q[WIDTH-2:0], q7_s};
                  state_d = (bit_q == '0) ? DONE : SHIFT_HI;
                end
      SHIFT_HI: if (div_end) begin
                  state_d = SHIFT_LO;
                  bit_d   = bit_q - BW'(1);
                end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // divider restarts on every state entry and never runs in IDLE
    div_d = (state_d != state_q || state_q == IDLE) ? '0 : div_q + DW'(1);
  end
  // outputs are registered from the next state so pins change with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      o_PL    <= PL_IDLE;
      o_CP    <= CP_IDLE;
      o_CE    <= CE_IDLE;
      rd_busy <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      o_PL    <= (state_d == LOAD) ? ~PL_IDLE : PL_IDLE;
      o_CP    <= (state_d == SHIFT_HI) ? ~CP_IDLE : CP_IDLE;
      o_CE    <= (state_d == SHIFT_LO || state_d == SHIFT_HI) ? ~CE_IDLE : CE_IDLE;
      rd_busy <= (state_d != IDLE);
      rd_vld  <= (state_d == DONE);
      if (state_d == DONE) rd_data <= sh_d;
    end
  end
endmodule

// File: doc/shift_reg_rd.md
Name: shift_reg_rd

Overview:
Reader for a 74HC165-style parallel-in/serial-out shift register chain (board buttons/DIP switches), the input-side counterpart of the 595 output driver.
- On request: pulses parallel-load, clocks WIDTH bits out of the chain MSB-first, and presents the captured word with a one-cycle valid strobe.
- Runs from the common 27 MHz clk. Serial clock is derived by a divide counter.

Parameters:
WIDTH, 8, number of bits in the chain (8 per '165 device; 16 for two cascaded).
CLK_DIV, 4, clk cycles per serial-clock half-period and per load pulse. Legal minimum is 3.

Ports:
clk  in  1  common clock, 27 MHz.
rst  in  1  reset; asynchronous, active-high.
rd_en  in  1  read request, sampled only in IDLE.
rd_busy  out  1  high while a frame is in progress (LOAD..DONE).
rd_vld  out  1  one-cycle strobe; rd_data updated in the same cycle.
rd_data  out  WIDTH  last captured word; bit WIDTH-1 = first bit shifted (D7 of first device).
o_PL  out  1  parallel load to chain, active-low.
o_CP  out  1  serial clock to chain; shifts on rising edge.
o_CE  out  1  clock-enable to chain, active-low.
i_Q7  in  1  serial data from chain; asynchronous to clk, so it is synchronised.

Behaviour:
- All outputs are registered, Moore-style.
- Reset values, applied immediately on rst:
  - State: IDLE.
  - Pins: o_PL=1, o_CP=0, o_CE=1.
  - Handshake/data: rd_busy=0, rd_vld=0, rd_data=0.
  - Internal: shift register, div counter and bit counter = 0.
- i_Q7 passes through a 2-FF synchroniser; all sampling uses the synchronised value.
- States are IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
- IDLE:
  - Pins at idle levels (o_PL=1, o_CP=0, o_CE=1); rd_busy=0.
  - If rd_en=1 at a rising edge (cycle T0): go to LOAD; rd_busy=1 from T0+1.
- LOAD:
  - o_PL=0, o_CE=1, o_CP=0 for exactly CLK_DIV cycles, then go to SHIFT_LO with bit index = WIDTH-1.
- SHIFT_LO:
  - o_PL=1, o_CE=0, o_CP=0 for CLK_DIV cycles.
  - On the last cycle, shift the synchronised Q7 into the LSB of the shift register (MSB-first capture).
  - Then: if bit index = 0 go to DONE, else go to SHIFT_HI.
- SHIFT_HI:
  - o_CP=1 for CLK_DIV cycles.
  - Then decrement bit index and go to SHIFT_LO.
- DONE (1 cycle):
  - rd_data <= shift register contents; rd_vld=1.
  - Pins at idle levels; rd_busy stays high in this cycle.
  - Next state: IDLE.
- Frame counts: WIDTH samples, exactly WIDTH-1 o_CP rising edges, and one o_PL low pulse of CLK_DIV cycles.
- Latency: rd_vld is high in cycle T0 + 1 + 2*WIDTH*CLK_DIV (T0+65 with defaults).
- rd_en handling:
  - rd_en while rd_busy=1 is ignored; it is not queued.
  - rd_en held high gives back-to-back frames with exactly one IDLE cycle between DONE and the next LOAD.
- rd_data holds its value between frames.
- Reset mid-frame: the frame is aborted, no rd_vld is produced, and rd_data is cleared to 0.
- Counter widths:
  - Divide counter: $clog2(CLK_DIV).
  - Bit counter: $clog2(WIDTH), minimum 1.
  - Neither counter wraps within a state; both reload on every state entry.

Decomposition:
- Shared package (shift_reg_pkg):
  - State enum for IDLE/LOAD/SHIFT_LO/SHIFT_HI/DONE.
  - Idle pin-level constants (PL_IDLE=1, CP_IDLE=0, CE_IDLE=1).
  - Default WIDTH and CLK_DIV values.
- One sub-module: sync_2ff, a 1-bit two-flop synchroniser with async active-high reset to 0. It is reusable by other board-input blocks.

Test Plan:
- Bench uses a behavioural 74HC165 model. It loads parallel input while o_PL=0, shifts on o_CP rising edge when o_CE=0, and drives Q7 combinationally.
- Defaults, parallel input 8'hA5, single-cycle rd_en at T0 -> rd_vld at T0+65 only; rd_data=8'hA5; o_PL low exactly 4 cycles; exactly 7 o_CP rising edges.
- Parallel input 8'h00, then 8'hFF -> rd_data=8'h00, then rd_data=8'hFF; no stuck bits.
- rd_en held high, model input changed 8'h3C -> 8'hC3 between frames -> rd_vld pulses 66 cycles apart with rd_data 8'h3C then 8'hC3.
- Extra rd_en pulses during rd_busy -> still exactly one rd_vld per accepted request; no extra frame.
- rst asserted at T0+20 mid SHIFT_HI -> same cycle: o_PL=1, o_CP=0, o_CE=1, rd_busy=0, rd_data=0; no rd_vld; next rd_en returns correct data.
- WIDTH=16, CLK_DIV=3, two cascaded models with input 16'hBEEF -> rd_vld at T0+97; rd_data=16'hBEEF; 15 o_CP edges.
